neander_mem: RTL and testbench
==============================

# neander_mem

Memory-side responder for the 4-bit Neander control FSM: a 16-word × 4-bit RAM with program counter (PC), memory address register (REM) and memory data register (RDM). It consumes the FSM strobes `selPC`, `enREM`, `write`, `selMEM` and `enPC`. It returns the fetched nibble as `op3..op0`, and it stores the accumulator value on STA-type writes. A preload port fills program memory while the core is stopped.

## Interface
- `DATA_W`, 4, data / opcode width
- `ADDR_W`, 4, address width; depth = 2^ADDR_W = 16
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `run`  in  1  1 = respond to FSM strobes; 0 = preload mode
- `selPC`  in  1  REM source: 1 = PC, 0 = RDM (operand address)
- `enREM`  in  1  load REM
- `write`  in  1  mem[REM] <= `acc_in`
- `selMEM`  in  1  RDM <= mem[REM]
- `enPC`  in  1  PC increment enable (low on halt opcode 4'hF)
- `acc_in`  in  DATA_W  accumulator value for writes
- `load_valid`  in  1  preload request
- `load_addr`  in  ADDR_W  preload address
- `load_data`  in  DATA_W  preload data
- `load_ready`  out  1  preload accepted this cycle
- `op3`, `op2`, `op1`, `op0`  out  1 each  RDM bits 3..0 to FSM/ALU
- `pc`  out  ADDR_W  current PC
- `rem`  out  ADDR_W  current REM
- `halted`  out  1  sticky: halt opcode fetched

## Operation
- **Reset** (`reset`=0, async): PC, REM, RDM, all 16 RAM words, `halted` = 0. `load_ready` = 0 while in reset.
- **Preload mode** (`run`=0):
  - `load_ready` = 1 combinationally.
  - On an edge with `load_valid`=1: mem[`load_addr`] <= `load_data`.
  - All FSM strobes are ignored; PC, REM and RDM hold.
- **Run mode** (`run`=1): `load_ready` = 0 and `load_valid` is ignored. On each edge:
  - **REM**: if `enREM`, REM <= (`selPC` ? PC : RDM).
  - **PC**: if `enREM` & `selPC` & `enPC`, PC <= PC+1 mod 16. The increment happens only on a fetch-address capture; 15 wraps to 0.
  - **RAM write**: if `write`, mem[REM] <= `acc_in`, using the REM value before this edge.
  - **RDM**: if `selMEM`, RDM <= mem[REM], using the REM value before this edge. If `write` and `selMEM` occur on the same edge, RDM <= `acc_in` (write-through).
  - **halted**: if `enREM` & `selPC` & ~`enPC`, `halted` <= 1. It clears only on reset.
- **Outputs**: `op3..op0` = RDM[3:0], registered with no combinational path from inputs.
- **Mode change**: a `run` change mid-sequence takes effect on the next edge; registers keep their values.

## Timing
- Read latency: REM captured at edge N (`enREM`); `selMEM` at edge N+1 loads RDM; `op*` valid after edge N+1.
- Write: visible to a read at the next edge or later; same-edge read observes it via write-through.
- PC update and REM capture share one edge; REM receives the old PC.
- Preload: one word per cycle, zero wait, no back-pressure in `run`=0.
- `reset` asserted mid-operation: all state clears immediately, without waiting for a clock edge. Release of `reset` is synchronized by the integrator.

## Structure
- Shared package: `DATA_W`, `ADDR_W`, and the halt opcode constant `OP_HLT = 4'hF`.
- One sub-module, `ram16x4`: synchronous write with async-reset clear and a combinational read port. PC, REM and RDM logic stay in `neander_mem`.

## Test plan
- **Reset:** with memory previously loaded, assert `reset`=0 mid-cycle. Require PC, REM, `op*`, `halted` and all words to be 0 immediately; a subsequent read of address 5 returns 0.
- **Preload then fetch:** preload mem[0]=4'h3 and mem[1]=4'hA with `run`=0. Set `run`=1 and apply `enREM`&`selPC`&`enPC`, then `selMEM`. Require REM=0, PC=1, and `op*`=4'h3 one edge later.
- **Operand indirection:** with RDM=4'h7 and mem[7]=4'h9, apply `enREM` with `selPC`=0, then `selMEM`. Require REM=7 and `op*`=4'h9.
- **Write and write-through:** with REM=4'h2 and `acc_in`=4'hC, apply `write`. A later read of address 2 returns 4'hC. Repeat with `write`+`selMEM` on the same edge: RDM=4'hC on that edge.
- **Halt and wrap:** PC=15 fetch with `enPC`=1 gives PC=0. A fetch with `enPC`=0 holds PC and sets `halted`=1; `halted` stays 1 until reset.
- **Mode gating:** with `run`=1, `load_valid`=1 leaves memory unchanged and `load_ready`=0. With `run`=0, strobes leave PC, REM and RDM unchanged.

Source files
------------

// File: rtl/neander_mem_pkg.sv
// Shared widths and constants for the Neander memory-side responder.
package neander_mem_pkg;

  parameter int unsigned DATA_W = 4;
  parameter int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] OP_HLT = 4'hF;

endpackage

// File: rtl/neander_mem_if.sv
// FSM strobe, preload and status bundle between the control FSM and neander_mem.
interface neander_mem_if import neander_mem_pkg::*; ();

  logic              run;
  logic              selPC;
  logic              enREM;
  logic              write;
  logic              selMEM;
  logic              enPC;
  logic [DATA_W-1:0] acc_in;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              op3;
  logic              op2;
  logic              op1;
  logic              op0;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rem;
  logic              halted;

  modport master (
    output run, selPC, enREM, write, selMEM, enPC, acc_in,
    output load_valid, load_addr, load_data,
    input  load_ready, op3, op2, op1, op0, pc, rem, halted
  );

  modport slave (
    input  run, selPC, enREM, write, selMEM, enPC, acc_in,
    input  load_valid, load_addr, load_data,
    output load_ready, op3, op2, op1, op0, pc, rem, halted
  );

endinterface

// File: rtl/ram16x4.sv
// 16 x 4 RAM: synchronous write, combinational read, every word cleared by async reset.
module ram16x4 import neander_mem_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/neander_mem.sv
// Neander memory responder: PC, REM and RDM around ram16x4, with a preload path when stopped.
module neander_mem import neander_mem_pkg::*; (
  input logic           clock,
  input logic           reset,
  neander_mem_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] rdm_q, rdm_d;
  logic              halted_q, halted_d;

  logic              fetch;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign fetch = bus.enREM & bus.selPC;

  // Preload owns the write port while stopped; the FSM owns it while running.
  assign ram_we    = bus.run ? bus.write : bus.load_valid;
  assign ram_waddr = bus.run ? rem_q : bus.load_addr;
  assign ram_wdata = bus.run ? bus.acc_in : bus.load_data;

  ram16x4 u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rem_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    pc_d     = pc_q;
    rem_d    = rem_q;
    rdm_d    = rdm_q;
    halted_d = halted_q;
    if (bus.run) begin
      if (bus.enREM) begin
        rem_d = bus.selPC ? pc_q : rdm_q;
      end
      if (fetch && bus.enPC) begin
        pc_d = pc_q + 1'b1;
      end
      if (fetch && !bus.enPC) begin
        halted_d = 1'b1;
      end
      // Same-edge write and read return the value being written.
      if (bus.selMEM) begin
        rdm_d = bus.write ? bus.acc_in : ram_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      rem_q    <= '0;
      rdm_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rem_q    <= rem_d;
      rdm_q    <= rdm_d;
      halted_q <= halted_d;
    end
  end

  assign bus.load_ready = ~bus.run & reset;
  assign bus.op3        = rdm_q[3];
  assign bus.op2        = rdm_q[2];
  assign bus.op1        = rdm_q[1];
  assign bus.op0        = rdm_q[0];
  assign bus.pc         = pc_q;
  assign bus.rem        = rem_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_neander_mem.sv
// Directed and randomized bench for neander_mem against a behavioural memory model.
module tb_neander_mem;
  import neander_mem_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  neander_mem_if bus ();

  neander_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  int m_mem [16];
  int m_pc;
  int m_rem;
  int m_rdm;
  int m_halt;

  function automatic int op_val();
    return int'({bus.op3, bus.op2, bus.op1, bus.op0});
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_pc   = 0;
    m_rem  = 0;
    m_rdm  = 0;
    m_halt = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},     int'(bus.pc), m_pc);
    chk({tag, ".rem"},    int'(bus.rem), m_rem);
    chk({tag, ".op"},     op_val(), m_rdm);
    chk({tag, ".halted"}, int'(bus.halted), m_halt);
    chk({tag, ".ready"},  int'(bus.load_ready), bus.run ? 0 : 1);
  endtask

  // One clock edge: update the model from the spec rules, then compare after the edge.
  task automatic cycle(input string tag);
    int nrem;
    @(posedge clock);
    if (!bus.run) begin
      if (bus.load_valid) m_mem[bus.load_addr] = int'(bus.load_data);
    end else begin
      nrem = m_rem;
      if (bus.enREM) nrem = bus.selPC ? m_pc : m_rdm;
      if (bus.write) m_mem[m_rem] = int'(bus.acc_in);
      if (bus.selMEM) m_rdm = m_mem[m_rem];
      if (bus.enREM && bus.selPC) begin
        if (bus.enPC) m_pc = (m_pc + 1) % 16;
        else m_halt = 1;
      end
      m_rem = nrem;
    end
    #1;
    chk_model(tag);
  endtask

  task automatic drive(input logic en_rem, input logic sel_pc, input logic en_pc,
                       input logic sel_mem, input logic wr);
    bus.enREM  = en_rem;
    bus.selPC  = sel_pc;
    bus.enPC   = en_pc;
    bus.selMEM = sel_mem;
    bus.write  = wr;
  endtask

  task automatic preload(input int addr, input int data);
    bus.run        = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_addr  = 4'(addr);
    bus.load_data  = 4'(data);
    cycle("preload");
    bus.load_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    reset          = 1'b0;
    bus.run        = 1'b0;
    bus.acc_in     = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst.ready", int'(bus.load_ready), 0);
    chk("rst.pc", int'(bus.pc), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle.ready", int'(bus.load_ready), 1);

    // Preload then fetch
    preload(0, 4'h3);
    preload(1, 4'hA);
    preload(2, 4'h7);
    preload(7, 4'h9);
    preload(3, 4'h2);
    bus.run = 1'b1;
    drive(1, 1, 1, 0, 0); cycle("fetch0");
    chk("fetch0.rem", int'(bus.rem), 0);
    chk("fetch0.pc", int'(bus.pc), 1);
    drive(0, 0, 0, 1, 0); cycle("read0");
    chk("read0.op", op_val(), 4'h3);

    // Operand indirection through mem[2] = 7
    drive(1, 1, 1, 0, 0); cycle("fetch1");
    drive(1, 1, 1, 0, 0); cycle("fetch2");
    drive(0, 0, 0, 1, 0); cycle("read2");
    chk("read2.op", op_val(), 4'h7);
    drive(1, 0, 0, 0, 0); cycle("ind.rem");
    chk("ind.rem7", int'(bus.rem), 7);
    drive(0, 0, 0, 1, 0); cycle("ind.read");
    chk("ind.op9", op_val(), 4'h9);

    // Write, later read, then write-through
    drive(1, 1, 1, 0, 0); cycle("fetch3");
    drive(0, 0, 0, 1, 0); cycle("read3");
    drive(1, 0, 0, 0, 0); cycle("rem2");
    chk("wr.rem2", int'(bus.rem), 2);
    bus.acc_in = 4'hC;
    drive(0, 0, 0, 0, 1); cycle("wr.c");
    drive(0, 0, 0, 1, 0); cycle("wr.readback");
    chk("wr.opC", op_val(), 4'hC);
    bus.acc_in = 4'h6;
    drive(0, 0, 0, 1, 1); cycle("wthru");
    chk("wthru.op6", op_val(), 4'h6);

    // Mode gating
    bus.load_valid = 1'b1;
    bus.load_addr  = 4'h2;
    bus.load_data  = 4'h1;
    drive(0, 0, 0, 0, 0); cycle("gate.load");
    chk("gate.ready0", int'(bus.load_ready), 0);
    bus.load_valid = 1'b0;
    drive(0, 0, 0, 1, 0); cycle("gate.read");
    chk("gate.mem2", op_val(), 4'h6);
    bus.run = 1'b0;
    drive(1, 1, 1, 1, 1); cycle("gate.strobes");
    chk("gate.pc", int'(bus.pc), 4);
    chk("gate.rem", int'(bus.rem), 2);
    chk("gate.op", op_val(), 4'h6);
    bus.run = 1'b1;

    // Wrap 15 -> 0 and halt
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) cycle("wrap.walk");
    chk("wrap.pc15", int'(bus.pc), 15);
    cycle("wrap");
    chk("wrap.pc0", int'(bus.pc), 0);
    chk("wrap.rem15", int'(bus.rem), 15);
    drive(1, 1, 0, 0, 0); cycle("halt");
    chk("halt.pc", int'(bus.pc), 0);
    chk("halt.set", int'(bus.halted), 1);
    drive(1, 1, 1, 1, 0); cycle("halt.sticky");
    chk("halt.sticky", int'(bus.halted), 1);

    // Randomized mix of strobes, mode flips and preloads
    for (int i = 0; i < 400; i++) begin
      bus.run        = ($urandom_range(0, 7) != 0);
      bus.enREM      = 1'($urandom);
      bus.selPC      = 1'($urandom);
      bus.enPC       = ($urandom_range(0, 15) != 0);
      bus.selMEM     = 1'($urandom);
      bus.write      = ($urandom_range(0, 3) == 0);
      bus.acc_in     = 4'($urandom);
      bus.load_valid = 1'($urandom);
      bus.load_addr  = 4'($urandom);
      bus.load_data  = 4'($urandom);
      cycle("rand");
    end

    // Asynchronous reset mid-cycle, then every word must read back 0
    bus.run        = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_addr  = 4'h5;
    bus.load_data  = OP_HLT;
    cycle("pre.rst");
    bus.load_valid = 1'b0;
    bus.run        = 1'b1;
    drive(1, 1, 0, 0, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst.pc", int'(bus.pc), 0);
    chk("arst.rem", int'(bus.rem), 0);
    chk("arst.op", op_val(), 0);
    chk("arst.halted", int'(bus.halted), 0);
    chk("arst.ready", int'(bus.load_ready), 0);
    @(negedge clock);
    reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 1, 0, 0); cycle("clr.fetch");
      drive(0, 0, 0, 1, 0); cycle("clr.read");
      chk("clr.word", op_val(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
